// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions.
// Two helpers live here:
//   jk_apply  - evaluates one JK cell: (current q, command) -> next q.
//   jk_excite - the inverse, the excitation table: (current q, wanted q) -> command.
// Don't-cares in the excitation table always resolve to HOLD, so JK_TOG is never produced.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_cmd_t;

    function automatic logic jk_apply(input logic q, input jk_cmd_t cmd);
        logic q_next;
        case (cmd)
            JK_HOLD: q_next = q;
            JK_CLR:  q_next = 1'b0;
            JK_SET:  q_next = 1'b1;
            default: q_next = ~q;
        endcase
        return q_next;
    endfunction

    function automatic jk_cmd_t jk_excite(input logic q, input logic q_next);
        jk_cmd_t cmd;
        case ({q, q_next})
            2'b01:   cmd = JK_SET;
            2'b10:   cmd = JK_CLR;
            default: cmd = JK_HOLD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/jk_excitation_encoder.sv
// Purely combinational JK excitation encoder.
// For each bit it picks the J/K drive that moves Q[i] to nxt[i].
// Ports:
//   Q   [WIDTH-1:0] in  - current state
//   nxt [WIDTH-1:0] in  - wanted next state
//   J   [WIDTH-1:0] out - per-bit J drive
//   K   [WIDTH-1:0] out - per-bit K drive
module jk_excitation_encoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K
);
    import jk_pkg::*;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_cmd_t cmd;
        assign cmd  = jk_excite(Q[i], nxt[i]);
        assign J[i] = cmd[1];
        assign K[i] = cmd[0];
    end

endmodule

// File: rtl/jk_excitation_counter.sv
// Mod-MODULUS up/down counter whose state is held in a bank of JK cells.
// Ports:
//   CLK     in  - rising-edge clock
//   not_RST in  - asynchronous, active-low reset (Q -> 0)
//   EN      in  - count enable
//   UP      in  - 1 = increment, 0 = decrement
//   LOAD    in  - synchronous load of D, clamped to MODULUS-1; overrides EN
//   D       in  - load value
//   Q       out - registered count
//   J, K    out - per-bit JK drive for the pending transition (combinational)
//   TC      out - terminal count: high in the cycle before a wrap (combinational)
module jk_excitation_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             CLK,
    input  logic             not_RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             TC
);
    import jk_pkg::*;

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("jk_excitation_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_CODE = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] nxt;

    // Unused codes above MAX_CODE only arise through corruption.
    // Counting up from one wraps to 0, and counting down saturates at MAX_CODE.
    always_comb begin
        nxt = q_q;
        if (LOAD) begin
            nxt = (D > MAX_CODE) ? MAX_CODE : D;
        end else if (EN) begin
            if (UP) begin
                nxt = (q_q >= MAX_CODE) ? '0 : q_q + WIDTH'(1);
            end else if (q_q == '0) begin
                nxt = MAX_CODE;
            end else if ((q_q - WIDTH'(1)) > MAX_CODE) begin
                nxt = MAX_CODE;
            end else begin
                nxt = q_q - WIDTH'(1);
            end
        end
    end

    jk_excitation_encoder #(
        .WIDTH (WIDTH)
    ) u_encoder (
        .Q   (q_q),
        .nxt (nxt),
        .J   (J),
        .K   (K)
    );

    // The state bank really evaluates each bit as a JK cell driven by the exported J/K.
    // That keeps the register honest to the drive seen by external discrete flip-flops.
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            q_d[i] = jk_apply(q_q[i], jk_cmd_t'({J[i], K[i]}));
        end
    end

    always_ff @(posedge CLK or negedge not_RST) begin
        if (!not_RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign TC = EN & ~LOAD & ((UP & (q_q == MAX_CODE)) | (~UP & (q_q == '0)));

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Self-checking bench for jk_excitation_counter (WIDTH = 4, MODULUS = 10).
// An integer model of the count drives a per-cycle compare on the falling edge.
// Directed sections pin literal values for the reset, wrap, load/clamp and hold cases.
// A randomised section then relies on the per-cycle compare, with occasional async reset pulses.
module tb_jk_excitation_counter;
    import jk_pkg::*;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             CLK     = 1'b0;
    logic             not_RST = 1'b1;
    logic             EN      = 1'b0;
    logic             UP      = 1'b0;
    logic             LOAD    = 1'b0;
    logic [WIDTH-1:0] D       = '0;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             TC;

    int checks   = 0;
    int failures = 0;

    int               mq         = 0;
    bit               rst_seen   = 1'b0;
    bit               cmp_en     = 1'b0;
    bit               prev_valid = 1'b0;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_j;
    logic [WIDTH-1:0] prev_k;
    int               exp_n;
    logic [WIDTH-1:0] mq4;
    logic [WIDTH-1:0] n4;
    logic [WIDTH-1:0] applied;
    bit               exp_tc;

    jk_excitation_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .CLK     (CLK),
        .not_RST (not_RST),
        .EN      (EN),
        .UP      (UP),
        .LOAD    (LOAD),
        .D       (D),
        .Q       (Q),
        .J       (J),
        .K       (K),
        .TC      (TC)
    );

    always #5 CLK = ~CLK;

    // Next count, taken directly from the priority rules.
    function automatic int model_next(input int q, input bit en, input bit up,
                                      input bit load, input int d);
        if (load)
            return (d < MODULUS) ? d : MODULUS - 1;
        if (en && up)
            return (q >= MODULUS - 1) ? 0 : q + 1;
        if (en && !up) begin
            if (q == 0)
                return MODULUS - 1;
            return (q - 1 > MODULUS - 1) ? MODULUS - 1 : q - 1;
        end
        return q;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit up, input bit load,
                                 input logic [WIDTH-1:0] d);
        EN   = en;
        UP   = up;
        LOAD = load;
        D    = d;
    endtask

    // Reference count: follows the async reset and advances on every rising edge.
    always @(posedge CLK or negedge not_RST) begin
        if (!not_RST) begin
            mq       = 0;
            rst_seen = 1'b1;
        end else begin
            mq = model_next(mq, EN, UP, LOAD, int'(D));
        end
    end

    // Per-cycle compare against the model and the JK trajectory invariants.
    always @(negedge CLK) begin
        if (cmp_en) begin
            exp_n  = model_next(mq, EN, UP, LOAD, int'(D));
            mq4    = mq[WIDTH-1:0];
            n4     = exp_n[WIDTH-1:0];
            exp_tc = EN && !LOAD && ((UP && mq == MODULUS - 1) || (!UP && mq == 0));
            checkOutput("model_Q", int'(Q), mq);
            checkOutput("model_J", int'(J), int'(~mq4 & n4));
            checkOutput("model_K", int'(K), int'(mq4 & ~n4));
            checkOutput("model_TC", int'(TC), int'(exp_tc));
            checkOutput("no_toggle", int'(J & K), 0);
            checkOutput("Q_in_range", int'(Q < WIDTH'(MODULUS)), 1);
            if (prev_valid && !rst_seen) begin
                for (int i = 0; i < WIDTH; i++)
                    applied[i] = jk_apply(prev_q[i], jk_cmd_t'({prev_j[i], prev_k[i]}));
                checkOutput("jk_apply_traj", int'(Q), int'(applied));
            end
            prev_q     = Q;
            prev_j     = J;
            prev_k     = K;
            prev_valid = 1'b1;
            rst_seen   = 1'b0;
        end
    end

    initial begin
        // Power-on reset
        #1 not_RST = 1'b0;
        #2 checkOutput("reset_Q", int'(Q), 0);
        @(posedge CLK);
        #2 not_RST = 1'b1;
        cmp_en = 1'b1;

        // Reset mid-count from Q = 7, asserted between edges
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd7);
        @(posedge CLK);
        #1 checkOutput("load7_Q", int'(Q), 7);
        #2 applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        not_RST = 1'b0;
        #1 checkOutput("async_reset_Q", int'(Q), 0);
        checkOutput("reset_J", int'(J), 4'b0001);
        checkOutput("reset_K", int'(K), 4'b0000);
        @(posedge CLK);
        #1 checkOutput("reset_hold_Q", int'(Q), 0);
        #1 not_RST = 1'b1;

        // Up-count wrap
        #1;
        for (int k = 0; k < 10; k++) begin
            checkOutput("up_Q", int'(Q), k);
            checkOutput("up_TC", int'(TC), int'(k == 9));
            if (k == 9) begin
                checkOutput("up9_J", int'(J), 4'b0000);
                checkOutput("up9_K", int'(K), 4'b1001);
            end
            @(posedge CLK);
            #1;
        end
        checkOutput("up_wrap_Q", int'(Q), 0);

        // Down-count wrap
        #1 UP = 1'b0;
        #1 checkOutput("down_TC", int'(TC), 1);
        checkOutput("down_J", int'(J), 4'b1001);
        checkOutput("down_K", int'(K), 4'b0000);
        @(posedge CLK);
        #1 checkOutput("down_wrap_Q", int'(Q), 9);
        @(posedge CLK);
        #1 checkOutput("down_next_Q", int'(Q), 8);

        // Load and clamp
        #1 applyStimulus(1'b1, 1'b0, 1'b1, 4'd5);
        @(posedge CLK);
        #1 checkOutput("load5_Q", int'(Q), 5);
        checkOutput("load5_TC", int'(TC), 0);
        #1 D = 4'd13;
        @(posedge CLK);
        #1 checkOutput("clamp_Q", int'(Q), 9);
        #1 D = 4'd5;
        @(posedge CLK);
        #1 checkOutput("reload5_Q", int'(Q), 5);
        checkOutput("same_load_J", int'(J), 0);
        checkOutput("same_load_K", int'(K), 0);

        // Hold
        #1 D = 4'd6;
        @(posedge CLK);
        #1 checkOutput("load6_Q", int'(Q), 6);
        #1 applyStimulus(1'b0, 1'b1, 1'b0, 4'd3);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1 checkOutput("hold_Q", int'(Q), 6);
            checkOutput("hold_J", int'(J), 0);
            checkOutput("hold_K", int'(K), 0);
            checkOutput("hold_TC", int'(TC), 0);
        end

        // Randomised run with occasional asynchronous reset pulses
        for (int c = 0; c < 1000; c++) begin
            @(posedge CLK);
            #2 applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0) begin
                #1 not_RST = 1'b0;
                #4 not_RST = 1'b1;
            end
        end

        @(posedge CLK);
        @(negedge CLK);
        #1 cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
